nbody_body_loader: RTL and testbench

Streaming writer that fills the N-body state BRAM with initial conditions before a simulation run. It accepts a framed stream of 16-bit words from the host side over a valid/ready handshake and unpacks each body into its five fields: x, y, vx, vy, mass, in that order. It writes each field word into the BRAM at a fixed per-body stride, verifies an XOR checksum, and reports done or error. The simulation controller reads the same BRAM and starts only after `load_done`.

---
 rtl/nbody_body_loader.sv | 112 +++++++++++
 tb/tb_nbody_body_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/nbody_body_loader.sv
// Streams a framed set of N-body initial conditions into the state BRAM.
// Frame: HEADER, 5N payload words (x, y, vx, vy, mass per body), XOR checksum.
module nbody_body_loader #(
  parameter int          N          = 16,
  parameter logic [15:0] HEADER     = 16'hB0D1,
  parameter int          RAM_ADDR_W = $clog2(N) + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  sim_busy,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  output logic                  ram_wren,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BODY = BW'(N - 1);

  typedef enum logic [1:0] {HUNT, LOAD, CSUM} state_t;

  state_t                  state, state_n;
  logic [BW-1:0]           body_idx, body_idx_n;
  logic [2:0]              field, field_n;
  logic [15:0]             csum, csum_n;
  logic [RAM_ADDR_W-1:0]   ram_addr_n;
  logic [15:0]             ram_wdata_n;
  logic                    ram_wren_n, load_done_n, load_error_n;
  logic                    accept;

  // sim_busy gates acceptance, so every counter freezes for free while stalled
  assign s_ready   = !reset && !sim_busy;
  assign accept    = s_valid && s_ready;
  assign load_busy = (state != HUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      body_idx   <= '0;
      field      <= '0;
      csum       <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_n;
      body_idx   <= body_idx_n;
      field      <= field_n;
      csum       <= csum_n;
      ram_addr   <= ram_addr_n;
      ram_wdata  <= ram_wdata_n;
      ram_wren   <= ram_wren_n;
      load_done  <= load_done_n;
      load_error <= load_error_n;
    end
  end

  always_comb begin
    state_n      = state;
    body_idx_n   = body_idx;
    field_n      = field;
    csum_n       = csum;
    ram_addr_n   = ram_addr;
    ram_wdata_n  = ram_wdata;
    ram_wren_n   = 1'b0;
    load_done_n  = load_done;
    load_error_n = load_error;
    case (state)
      HUNT: begin
        if (accept && s_data == HEADER) begin
          body_idx_n   = '0;
          field_n      = '0;
          csum_n       = '0;
          load_done_n  = 1'b0;
          load_error_n = 1'b0;
          state_n      = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          ram_wren_n  = 1'b1;
          ram_addr_n  = RAM_ADDR_W'({body_idx, field});
          ram_wdata_n = s_data;
          csum_n      = csum ^ s_data;
          if (field == 3'd4) begin
            field_n    = '0;
            body_idx_n = body_idx + 1'b1;
            if (body_idx == LAST_BODY) state_n = CSUM;
          end else begin
            field_n = field + 3'd1;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          load_done_n  = (s_data == csum);
          load_error_n = (s_data != csum);
          state_n      = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

endmodule

// File: tb/tb_nbody_body_loader.sv
// Scoreboard bench: frame tasks push expected BRAM writes, a negedge monitor pops them.
module tb_nbody_body_loader;
  localparam int          NB  = 16;
  localparam int          NW  = 5 * NB;
  localparam logic [15:0] HDR = 16'hB0D1;
  localparam int          AW  = $clog2(NB) + 3;

  logic          clk = 0, reset = 1, s_valid = 0, sim_busy = 0;
  logic [15:0]   s_data = 0;
  logic          s_ready, ram_wren, load_busy, load_done, load_error;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;

  int n_cmp = 0, n_err = 0;

  typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];

  nbody_body_loader #(.N(NB), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sim_busy(sim_busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT issues must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", ram_addr, ram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_wdata), 32'(e.data));
      end
    end
  end

  // Present one word, optionally after idle gap cycles and a sim_busy stall.
  task automatic send(input logic [15:0] w, input int gap, input int busy);
    int guard;
    s_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_data = w; s_valid = 1;
    if (busy > 0) begin
      sim_busy = 1;
      repeat (busy) begin
        @(negedge clk);
        check("stall_s_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
      end
      sim_busy = 0;
    end
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!s_ready && guard < 200);
    if (!s_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: word %h never accepted", w);
    end
    #1;
  endtask

  // Full frame. stall_at/stall_len inject sim_busy before payload word stall_at;
  // abort_at >= 0 resets the DUT after that many payload words.
  task automatic send_frame(input logic [15:0] pl[NW], input logic bad, input int max_gap,
                            input int stall_at, input int stall_len, input int abort_at);
    logic [15:0] x;
    x = 16'h0;
    send(HDR, 0, 0);
    @(negedge clk);
    check("hdr_busy", 32'(load_busy), 1);
    check("hdr_done_clr", 32'({load_done, load_error}), 0);
    for (int k = 0; k < NW; k++) begin
      if (k == abort_at) begin
        reset = 1;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        check("rst_outputs", 32'({ram_wren, ram_addr, ram_wdata, load_busy, load_done, load_error}), 0);
        reset = 0; s_valid = 0;
        return;
      end
      exp_q.push_back('{addr: AW'(8 * (k / 5) + (k % 5)), data: pl[k]});
      x ^= pl[k];
      send(pl[k], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0, (k == stall_at) ? stall_len : 0);
    end
    @(negedge clk);
    check("pre_csum_busy", 32'(load_busy), 1);
    send(bad ? (x ^ 16'h0001) : x, 0, 0);
    s_valid = 0;
    @(negedge clk);
    check("done", 32'(load_done), 32'(!bad));
    check("error", 32'(load_error), 32'(bad));
    check("post_busy", 32'(load_busy), 0);
  endtask

  logic [15:0] pl [NW];
  logic        bad;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_s_ready", 32'(s_ready), 0);
    check("reset_outputs", 32'({ram_wren, ram_addr, ram_wdata, load_busy, load_done, load_error}), 0);
    reset = 0;
    @(posedge clk); #1;

    for (int k = 0; k < NW; k++) pl[k] = 16'(k);
    send_frame(pl, 1'b0, 0, -1, 0, -1);               // good sequential frame
    send_frame(pl, 1'b1, 0, -1, 0, -1);               // bad checksum, reload clears done
    send(16'h1234, 0, 0);                             // garbage before sync
    send(16'hFFFF, 0, 0);
    @(negedge clk);
    check("hunt_idle", 32'({load_busy, load_error}), 32'(2'b01));
    send_frame(pl, 1'b0, 0, 7, 10, -1);               // stall after 7 words
    send_frame(pl, 1'b0, 0, -1, 0, 37);               // reset mid-load
    send_frame(pl, 1'b0, 0, -1, 0, -1);               // fresh frame after reset

    for (int f = 0; f < 6; f++) begin                 // randomized frames
      for (int k = 0; k < NW; k++) pl[k] = 16'($urandom);
      pl[$urandom_range(NW - 1, 0)] = HDR;            // header inside payload is data
      bad = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) send(16'($urandom) | 16'h0001, 0, 0);
      send_frame(pl, bad, 2, $urandom_range(NW - 1, 0), $urandom_range(5, 1), -1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
